// File: rtl/note_render_pkg.sv
// Shared constants, colours and the slot record used by the note lane renderer.
// Optional feature macro: NOTE_LANE_DIVIDER_EN (grey divider at the left edge of each lane).
package note_render_pkg;

   localparam int LANE_W      = 160;
   localparam int LANES       = 4;
   localparam int NOTE_MARGIN = 16;
   localparam int SCREEN_H    = 480;

   localparam logic [7:0] LANE0_COLOUR   = 8'hE0;
   localparam logic [7:0] LANE1_COLOUR   = 8'h1C;
   localparam logic [7:0] LANE2_COLOUR   = 8'h03;
   localparam logic [7:0] LANE3_COLOUR   = 8'hFC;
   localparam logic [7:0] LINE_COLOUR    = 8'hFF;
   localparam logic [7:0] DIVIDER_COLOUR = 8'h49;

   // One falling note: {active, lane[1:0], y[9:0]}
   typedef struct packed {
      logic       active;
      logic [1:0] lane;
      logic [9:0] y;
   } slot_t;

   function automatic logic [7:0] lane_colour(input logic [1:0] lane);
      logic [7:0] colour;
      case (lane)
         2'd0:    colour = LANE0_COLOUR;
         2'd1:    colour = LANE1_COLOUR;
         2'd2:    colour = LANE2_COLOUR;
         default: colour = LANE3_COLOUR;
      endcase
      return colour;
   endfunction

endpackage

// File: rtl/note_slot.sv
// One note slot: holds its record, scrolls on frame ticks, loads on spawn,
// reports whether it sits in the hit window and whether it covers the current pixel.
module note_slot
   import note_render_pkg::*;
#(
   parameter int SPEED   = 4,
   parameter int HIT_Y   = 440,
   parameter int HIT_WIN = 12,
   parameter int NOTE_H  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick_i,
   input  logic       spawn_i,
   input  logic [1:0] spawn_lane_i,
   input  logic       hit_clear_i,
   input  logic [8:0] pix_y_i,
   input  logic [1:0] pix_lane_i,
   input  logic       pix_lane_ok_i,
   output logic       active_o,
   output logic [1:0] lane_o,
   output logic       in_window_o,
   output logic       cover_o,
   output logic       miss_o
);

   slot_t slot_q, slot_d;

   logic [10:0] y_ext;
   logic [10:0] scroll_sum;
   logic [10:0] centre;
   logic [10:0] pix_y_ext;

   // Widened copies so the scroll, window and cover compares cannot wrap
   always_comb begin
      y_ext      = {1'b0, slot_q.y};
      scroll_sum = y_ext + 11'(SPEED);
      centre     = y_ext + 11'(NOTE_H / 2);
      pix_y_ext  = {2'b00, pix_y_i};
   end

   // Hit-window, pixel-cover and miss flags seen by the top level
   always_comb begin
      active_o    = slot_q.active;
      lane_o      = slot_q.lane;
      in_window_o = slot_q.active
                    && (centre >= 11'(HIT_Y - HIT_WIN))
                    && (centre <= 11'(HIT_Y + HIT_WIN));
      cover_o     = slot_q.active && pix_lane_ok_i && (slot_q.lane == pix_lane_i)
                    && (pix_y_ext >= y_ext) && (pix_y_ext < y_ext + 11'(NOTE_H));
      miss_o      = slot_q.active && frame_tick_i && !hit_clear_i
                    && (scroll_sum >= 11'(SCREEN_H));
   end

   // Next slot state: a hit wins over scrolling, spawning only targets a free slot
   always_comb begin
      slot_d = slot_q;
      if (hit_clear_i) begin
         slot_d = '0;
      end else if (slot_q.active && frame_tick_i) begin
         if (scroll_sum >= 11'(SCREEN_H)) begin
            slot_d = '0;
         end else begin
            slot_d.y = scroll_sum[9:0];
         end
      end else if (spawn_i && !slot_q.active) begin
         slot_d.active = 1'b1;
         slot_d.lane   = spawn_lane_i;
         slot_d.y      = '0;
      end
   end

   // Slot record register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/note_lane_renderer.sv
// Pixel colour stage after the VGA sync generator: four-lane falling-note renderer
// with hit judging. Optional macro NOTE_LANE_DIVIDER_EN draws grey lane dividers.
module note_lane_renderer
   import note_render_pkg::*;
#(
   parameter int SLOTS   = 8,
   parameter int SPEED   = 4,
   parameter int HIT_Y   = 440,
   parameter int HIT_WIN = 12,
   parameter int NOTE_H  = 16
) (
   input  logic       pixel_clk,
   input  logic       rst_n,
   input  logic [9:0] counter_x,
   input  logic [8:0] counter_y,
   input  logic       in_display_area,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   input  logic       note_valid,
   input  logic [1:0] note_lane,
   output logic       note_ready,
   input  logic [3:0] hit_pad,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic [7:0] vga_rgb,
   output logic       h_sync_out,
   output logic       v_sync_out
);

   logic             v_prev_q;
   logic             frame_tick;
   logic             any_free;
   logic             spawn_accept;
   logic [SLOTS-1:0] free_sel;
   logic [SLOTS-1:0] hit_clear;
   logic [3:0]       lane_matched;

   logic [SLOTS-1:0] slot_active;
   logic [SLOTS-1:0] slot_win;
   logic [SLOTS-1:0] slot_cover;
   logic [SLOTS-1:0] slot_miss;
   logic [1:0]       slot_lane [SLOTS];

   logic [1:0]       pix_lane;
   logic             pix_lane_ok;
   logic [9:0]       x_off;
   logic             in_lane;
   logic             line_px;

   logic             de_q, note_q, in_lane_q, line_q, hs1_q, vs1_q;
   logic [1:0]       lane_q;
   logic             hit_pulse_q, miss_pulse_q;
   logic [7:0]       rgb_d, rgb_q;
   logic             hs2_q, vs2_q;

`ifdef NOTE_LANE_DIVIDER_EN
   logic             div_px;
   logic             div_q;
`endif

   // Frame tick on the vsync falling edge; no spawns are taken in that cycle
   always_comb begin
      frame_tick   = v_prev_q && !v_sync_in;
      note_ready   = any_free && !frame_tick;
      spawn_accept = note_valid && note_ready;
   end

   // Lowest-index free slot gets the spawn; per lane, lowest-index slot in the window gets the hit
   always_comb begin
      free_sel     = '0;
      any_free     = 1'b0;
      hit_clear    = '0;
      lane_matched = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!slot_active[i] && !any_free) begin
            free_sel[i] = 1'b1;
            any_free    = 1'b1;
         end
      end
      for (int l = 0; l < LANES; l++) begin
         for (int i = 0; i < SLOTS; i++) begin
            if (hit_pad[l] && !lane_matched[l] && slot_win[i] && (slot_lane[i] == 2'(l))) begin
               hit_clear[i]    = 1'b1;
               lane_matched[l] = 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      note_slot #(
         .SPEED   (SPEED),
         .HIT_Y   (HIT_Y),
         .HIT_WIN (HIT_WIN),
         .NOTE_H  (NOTE_H)
      ) u_slot (
         .clk           (pixel_clk),
         .rst_n         (rst_n),
         .frame_tick_i  (frame_tick),
         .spawn_i       (spawn_accept && free_sel[i]),
         .spawn_lane_i  (note_lane),
         .hit_clear_i   (hit_clear[i]),
         .pix_y_i       (counter_y),
         .pix_lane_i    (pix_lane),
         .pix_lane_ok_i (pix_lane_ok),
         .active_o      (slot_active[i]),
         .lane_o        (slot_lane[i]),
         .in_window_o   (slot_win[i]),
         .cover_o       (slot_cover[i]),
         .miss_o        (slot_miss[i])
      );
   end

   // Split the raster x into a lane index and an offset within that lane
   always_comb begin
      pix_lane    = 2'd0;
      pix_lane_ok = 1'b1;
      x_off       = counter_x;
      if (counter_x >= 10'(4 * LANE_W)) begin
         pix_lane_ok = 1'b0;
      end else if (counter_x >= 10'(3 * LANE_W)) begin
         pix_lane = 2'd3;
         x_off    = counter_x - 10'(3 * LANE_W);
      end else if (counter_x >= 10'(2 * LANE_W)) begin
         pix_lane = 2'd2;
         x_off    = counter_x - 10'(2 * LANE_W);
      end else if (counter_x >= 10'(LANE_W)) begin
         pix_lane = 2'd1;
         x_off    = counter_x - 10'(LANE_W);
      end
      in_lane = pix_lane_ok && (x_off >= 10'(NOTE_MARGIN))
                && (x_off < 10'(LANE_W - NOTE_MARGIN));
      line_px = (counter_y == 9'(HIT_Y));
`ifdef NOTE_LANE_DIVIDER_EN
      div_px  = pix_lane_ok && (x_off == 10'd0);
`endif
   end

   // vsync edge detector and the one-cycle hit/miss pulses
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         v_prev_q     <= 1'b1;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
      end else begin
         v_prev_q     <= v_sync_in;
         hit_pulse_q  <= |hit_clear;
         miss_pulse_q <= |slot_miss;
      end
   end

   // Pixel stage 1: register the coverage flags alongside display-area and syncs
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         de_q      <= 1'b0;
         note_q    <= 1'b0;
         in_lane_q <= 1'b0;
         line_q    <= 1'b0;
         lane_q    <= 2'd0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
`ifdef NOTE_LANE_DIVIDER_EN
         div_q     <= 1'b0;
`endif
      end else begin
         de_q      <= in_display_area;
         note_q    <= |slot_cover;
         in_lane_q <= in_lane;
         line_q    <= line_px;
         lane_q    <= pix_lane;
         hs1_q     <= h_sync_in;
         vs1_q     <= v_sync_in;
`ifdef NOTE_LANE_DIVIDER_EN
         div_q     <= div_px;
`endif
      end
   end

   // Pixel stage 2 colour priority: blanking, note, hit line, then divider
   always_comb begin
      rgb_d = 8'h00;
      if (!de_q) begin
         rgb_d = 8'h00;
      end else if (note_q && in_lane_q) begin
         rgb_d = lane_colour(lane_q);
      end else if (line_q) begin
         rgb_d = LINE_COLOUR;
`ifdef NOTE_LANE_DIVIDER_EN
      end else if (div_q) begin
         rgb_d = DIVIDER_COLOUR;
`endif
      end
   end

   // Pixel stage 2 register with syncs delayed to match
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= 8'h00;
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
      end else begin
         rgb_q <= rgb_d;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   assign vga_rgb    = rgb_q;
   assign h_sync_out = hs2_q;
   assign v_sync_out = vs2_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_note_lane_renderer.sv
// Self-checking bench for note_lane_renderer: table-driven pixel vectors plus
// hand-written spawn, hit, miss and sync sequences. Honours NOTE_LANE_DIVIDER_EN.
module tb_note_lane_renderer;

   logic       pixel_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] counter_x = '0;
   logic [8:0] counter_y = '0;
   logic       in_display_area = 1'b0;
   logic       h_sync_in = 1'b1;
   logic       v_sync_in = 1'b1;
   logic       note_valid = 1'b0;
   logic [1:0] note_lane = '0;
   logic       note_ready;
   logic [3:0] hit_pad = '0;
   logic       hit_pulse;
   logic       miss_pulse;
   logic [7:0] vga_rgb;
   logic       h_sync_out;
   logic       v_sync_out;

   int applied = 0;
   int miscompares = 0;

`ifdef NOTE_LANE_DIVIDER_EN
   localparam logic [7:0] DIV_EXP = 8'h49;
`else
   localparam logic [7:0] DIV_EXP = 8'h00;
`endif

   typedef struct {
      logic [9:0] x;
      logic [8:0] y;
      logic       de;
      logic [7:0] exp;
      string      name;
   } pix_vec_t;

   pix_vec_t vecs[$];

   note_lane_renderer dut (
      .pixel_clk       (pixel_clk),
      .rst_n           (rst_n),
      .counter_x       (counter_x),
      .counter_y       (counter_y),
      .in_display_area (in_display_area),
      .h_sync_in       (h_sync_in),
      .v_sync_in       (v_sync_in),
      .note_valid      (note_valid),
      .note_lane       (note_lane),
      .note_ready      (note_ready),
      .hit_pad         (hit_pad),
      .hit_pulse       (hit_pulse),
      .miss_pulse      (miss_pulse),
      .vga_rgb         (vga_rgb),
      .h_sync_out      (h_sync_out),
      .v_sync_out      (v_sync_out)
   );

   always #5 pixel_clk = ~pixel_clk;

   // Compare one observed value with its hand-computed expectation
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   // Present one raster position and wait out the two-stage pixel latency
   task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic de);
      counter_x       = x;
      counter_y       = y;
      in_display_area = de;
      @(negedge pixel_clk);
      @(negedge pixel_clk);
   endtask

   task automatic checkPixel(input string name, input logic [9:0] x, input logic [8:0] y,
                             input logic de, input logic [7:0] expected);
      applyStimulus(x, y, de);
      checkOutput(name, vga_rgb, expected);
      in_display_area = 1'b0;
   endtask

   task automatic doReset();
      rst_n      = 1'b0;
      note_valid = 1'b0;
      hit_pad    = '0;
      v_sync_in  = 1'b1;
      h_sync_in  = 1'b1;
      repeat (2) @(negedge pixel_clk);
      rst_n = 1'b1;
      @(negedge pixel_clk);
   endtask

   task automatic spawnNote(input logic [1:0] lane, input string name);
      checkOutput(name, {7'd0, note_ready}, 8'd1);
      note_valid = 1'b1;
      note_lane  = lane;
      @(negedge pixel_clk);
      note_valid = 1'b0;
   endtask

   // One vsync falling edge; reports the pulses seen right after the tick
   task automatic frameTick(output logic missSeen, output logic hitSeen);
      v_sync_in = 1'b0;
      @(negedge pixel_clk);
      missSeen  = miss_pulse;
      hitSeen   = hit_pulse;
      v_sync_in = 1'b1;
      @(negedge pixel_clk);
   endtask

   task automatic ticks(input int n, output logic anyMiss);
      logic m, h;
      anyMiss = 1'b0;
      for (int i = 0; i < n; i++) begin
         frameTick(m, h);
         anyMiss = anyMiss | m;
      end
   endtask

   task automatic strike(input logic [3:0] mask, input logic expHit, input string name);
      hit_pad = mask;
      @(negedge pixel_clk);
      checkOutput(name, {7'd0, hit_pulse}, {7'd0, expHit});
      hit_pad = '0;
      @(negedge pixel_clk);
      checkOutput({name, "_drop"}, {7'd0, hit_pulse}, 8'd0);
   endtask

   task automatic addVec(input logic [9:0] x, input logic [8:0] y, input logic de,
                         input logic [7:0] exp, input string name);
      pix_vec_t v;
      v.x = x; v.y = y; v.de = de; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      logic m, h, anyMiss;
      logic hHist [$];
      logic vHist [$];
      logic hNew, vNew;

      // Lane 1 note at y=40 after spawn and 10 ticks: covers rows 40..55, x 176..303
      addVec(10'd200, 9'd45,  1'b1, 8'h1C, "note_mid");
      addVec(10'd200, 9'd39,  1'b1, 8'h00, "above_note");
      addVec(10'd200, 9'd55,  1'b1, 8'h1C, "note_last_row");
      addVec(10'd200, 9'd56,  1'b1, 8'h00, "below_note");
      addVec(10'd170, 9'd45,  1'b1, 8'h00, "left_margin");
      addVec(10'd176, 9'd45,  1'b1, 8'h1C, "x_off_16");
      addVec(10'd303, 9'd45,  1'b1, 8'h1C, "x_off_143");
      addVec(10'd304, 9'd45,  1'b1, 8'h00, "x_off_144");
      addVec(10'd40,  9'd45,  1'b1, 8'h00, "other_lane");
      addVec(10'd200, 9'd45,  1'b0, 8'h00, "blanked");
      addVec(10'd200, 9'd440, 1'b1, 8'hFF, "hit_line");
      addVec(10'd700, 9'd440, 1'b1, 8'hFF, "hit_line_right");
      addVec(10'd160, 9'd100, 1'b1, DIV_EXP, "divider_lane1");
      addVec(10'd0,   9'd100, 1'b1, DIV_EXP, "divider_lane0");
      addVec(10'd0,   9'd100, 1'b0, 8'h00, "divider_blanked");

      // Reset state
      repeat (2) @(negedge pixel_clk);
      checkOutput("rst_rgb",    vga_rgb,                8'h00);
      checkOutput("rst_hit",    {7'd0, hit_pulse},      8'd0);
      checkOutput("rst_miss",   {7'd0, miss_pulse},     8'd0);
      checkOutput("rst_hsync",  {7'd0, h_sync_out},     8'd1);
      checkOutput("rst_vsync",  {7'd0, v_sync_out},     8'd1);
      checkOutput("rst_ready",  {7'd0, note_ready},     8'd1);
      rst_n = 1'b1;
      @(negedge pixel_clk);

      // Spawn in lane 1, scroll ten frames, run the pixel table
      $display("[TB] pixel table");
      spawnNote(2'd1, "ready_first");
      ticks(10, anyMiss);
      foreach (vecs[i]) checkPixel(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].exp);

      // Fill all eight slots, hold a ninth request until a hit frees slot 0
      $display("[TB] full slots");
      doReset();
      for (int i = 0; i < 8; i++) spawnNote(2'd0, "ready_fill");
      checkOutput("ready_full", {7'd0, note_ready}, 8'd0);
      note_valid = 1'b1;
      note_lane  = 2'd3;
      ticks(107, anyMiss);
      checkOutput("ready_still_full", {7'd0, note_ready}, 8'd0);
      hit_pad = 4'b0001;
      @(negedge pixel_clk);
      checkOutput("full_hit", {7'd0, hit_pulse}, 8'd1);
      checkOutput("ready_after_hit", {7'd0, note_ready}, 8'd1);
      hit_pad = '0;
      @(negedge pixel_clk);
      checkOutput("ready_after_accept", {7'd0, note_ready}, 8'd0);
      note_valid = 1'b0;
      checkPixel("held_note_lane3", 10'd500, 9'd5, 1'b1, 8'hFC);
      checkPixel("remaining_lane0", 10'd50, 9'd430, 1'b1, 8'hE0);

      // Hit window: outside at y=400, wrong lane, then inside at y=428
      $display("[TB] hit window");
      doReset();
      spawnNote(2'd2, "ready_lane2");
      ticks(100, anyMiss);
      strike(4'b0100, 1'b0, "early_strike");
      checkPixel("kept_after_early", 10'd400, 9'd405, 1'b1, 8'h03);
      ticks(7, anyMiss);
      strike(4'b0010, 1'b0, "wrong_lane_strike");
      strike(4'b0100, 1'b1, "window_strike");
      checkPixel("cleared_after_hit", 10'd400, 9'd430, 1'b1, 8'h00);

      // Miss: y=476 scrolls to 480 and leaves the screen
      $display("[TB] miss");
      doReset();
      spawnNote(2'd0, "ready_miss");
      ticks(119, anyMiss);
      checkOutput("no_early_miss", {7'd0, anyMiss}, 8'd0);
      checkPixel("at_476", 10'd50, 9'd478, 1'b1, 8'hE0);
      frameTick(m, h);
      checkOutput("miss_pulse", {7'd0, m}, 8'd1);
      checkOutput("miss_drop", {7'd0, miss_pulse}, 8'd0);
      checkPixel("gone_after_miss", 10'd50, 9'd478, 1'b1, 8'h00);

      // Hit and frame tick together on a note at y=436
      $display("[TB] hit with tick");
      doReset();
      spawnNote(2'd3, "ready_lane3");
      ticks(109, anyMiss);
      v_sync_in = 1'b0;
      hit_pad   = 4'b1000;
      @(negedge pixel_clk);
      checkOutput("tick_hit", {7'd0, hit_pulse}, 8'd1);
      checkOutput("tick_no_miss", {7'd0, miss_pulse}, 8'd0);
      v_sync_in = 1'b1;
      hit_pad   = '0;
      @(negedge pixel_clk);
      checkOutput("tick_hit_drop", {7'd0, hit_pulse}, 8'd0);
      ticks(12, anyMiss);
      checkOutput("no_later_miss", {7'd0, anyMiss}, 8'd0);
      checkPixel("gone_after_tick_hit", 10'd500, 9'd445, 1'b1, 8'h00);

      // Syncs follow the inputs exactly two cycles later
      $display("[TB] sync alignment");
      doReset();
      hHist = '{1'b1, 1'b1};
      vHist = '{1'b1, 1'b1};
      for (int k = 0; k < 24; k++) begin
         checkOutput("hsync_delay", {7'd0, h_sync_out}, {7'd0, hHist[0]});
         checkOutput("vsync_delay", {7'd0, v_sync_out}, {7'd0, vHist[0]});
         hNew = 1'($urandom_range(0, 1));
         vNew = 1'($urandom_range(0, 1));
         h_sync_in = hNew;
         v_sync_in = vNew;
         void'(hHist.pop_front());
         void'(vHist.pop_front());
         hHist.push_back(hNew);
         vHist.push_back(vNew);
         @(negedge pixel_clk);
      end
      h_sync_in = 1'b1;
      v_sync_in = 1'b1;
      repeat (2) @(negedge pixel_clk);

      // Pixel latency is exactly two cycles, and the hit line spans the visible row
      counter_x       = 10'd100;
      counter_y       = 9'd440;
      in_display_area = 1'b1;
      @(negedge pixel_clk);
      checkOutput("latency_one_cycle", vga_rgb, 8'h00);
      @(negedge pixel_clk);
      checkOutput("latency_two_cycles", vga_rgb, 8'hFF);
      in_display_area = 1'b0;
      for (int x = 0; x < 640; x += 80) checkPixel("line_scan", 10'(x), 9'd440, 1'b1, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
